// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending money path.
package vend_pkg;
  typedef logic [6:0] credit_t;
  typedef enum logic [1:0] {NICKEL = 2'd0, DIME = 2'd1, QUARTER = 2'd2} coin_e;

  localparam credit_t NICKEL_VAL  = 7'd5;
  localparam credit_t DIME_VAL    = 7'd10;
  localparam credit_t QUARTER_VAL = 7'd25;

  function automatic credit_t coin_value(input coin_e c);
    case (c)
      QUARTER: coin_value = QUARTER_VAL;
      DIME:    coin_value = DIME_VAL;
      default: coin_value = NICKEL_VAL;
    endcase
  endfunction
endpackage

// File: rtl/change_picker.sv
// Greedy change selection: largest coin not exceeding the credit.
module change_picker
  import vend_pkg::*;
(
  input  credit_t credit,
  output coin_e   coin,
  output logic    valid
);
  always_comb begin
    valid = (credit >= NICKEL_VAL);
    if (credit >= QUARTER_VAL)   coin = QUARTER;
    else if (credit >= DIME_VAL) coin = DIME;
    else                         coin = NICKEL;
  end
endmodule

// File: rtl/credit_bank.sv
// Credit register, debit/coin arithmetic and change dispenser.
// Optional idle auto-refund enabled by defining AUTO_REFUND_EN.
module credit_bank
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT   = 127,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Coin,
  input  logic [6:0] Debit,
  input  logic       DebitValid,
  input  logic       Refund,
  input  logic       EjectReady,
  output logic [6:0] Money,
  output logic       EjectValid,
  output logic [1:0] EjectType,
  output logic       CoinReject,
  output logic       DebitErr,
  output logic       Busy
);
  if (MAX_CREDIT > 127 || MAX_CREDIT < 25 || IDLE_TIMEOUT < 2) begin : g_bad_cfg
    $error("credit_bank: illegal parameter set");
  end

  typedef enum logic {IDLE = 1'b0, DISPENSE = 1'b1} state_e;
  localparam logic [7:0] MAX8 = 8'(MAX_CREDIT);

  state_e     state, state_n;
  credit_t    money, money_n;
  logic       coin_rej_n, debit_err_n;
  logic       coin_bad, debit_ok, refund_req;
  credit_t    coin_val, rem;
  logic [7:0] after_debit, after_coin;
  coin_e      pick;
  logic       pick_ok;

  change_picker u_pick (.credit(money), .coin(pick), .valid(pick_ok));

  always_comb begin
    coin_bad = 1'b0;
    coin_val = '0;
    case (Coin)
      3'b000: ;
      3'b001: coin_val = coin_value(NICKEL);
      3'b010: coin_val = coin_value(DIME);
      3'b100: coin_val = coin_value(QUARTER);
      default: coin_bad = 1'b1;
    endcase
  end

`ifdef AUTO_REFUND_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          activity, auto_fire;

  assign activity  = (Coin != 3'b000) || DebitValid || Refund;
  assign auto_fire = (state == IDLE) && (money != '0) && !activity &&
                     (idle_cnt == TW'(IDLE_TIMEOUT - 1));
  assign refund_req = Refund || auto_fire;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) idle_cnt <= '0;
    else if (state != IDLE || money == '0 || activity || auto_fire) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign refund_req = Refund;
`endif

  always_comb begin
    state_n     = state;
    money_n     = money;
    coin_rej_n  = 1'b0;
    debit_err_n = 1'b0;
    debit_ok    = DebitValid && (Debit <= money);
    after_debit = {1'b0, money} - (debit_ok ? {1'b0, Debit} : 8'd0);
    after_coin  = after_debit;
    rem         = money - coin_value(pick);
    case (state)
      IDLE: begin
        if (DebitValid && !debit_ok) debit_err_n = 1'b1;
        // coin is judged against the already-debited credit
        if (Coin != 3'b000) begin
          if (coin_bad || (after_debit + {1'b0, coin_val}) > MAX8) coin_rej_n = 1'b1;
          else after_coin = after_debit + {1'b0, coin_val};
        end
        money_n = after_coin[6:0];
        if (refund_req) begin
          if (after_coin >= 8'(NICKEL_VAL)) state_n = DISPENSE;
          else money_n = '0;
        end
      end
      DISPENSE: begin
        coin_rej_n  = (Coin != 3'b000);
        debit_err_n = DebitValid;
        if (!pick_ok) begin
          state_n = IDLE;
          money_n = '0;
        end else if (EjectReady) begin
          // leave as soon as the residue can no longer buy a coin
          if (rem < NICKEL_VAL) begin
            state_n = IDLE;
            money_n = '0;
          end else money_n = rem;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      money      <= '0;
      CoinReject <= 1'b0;
      DebitErr   <= 1'b0;
    end else begin
      state      <= state_n;
      money      <= money_n;
      CoinReject <= coin_rej_n;
      DebitErr   <= debit_err_n;
    end
  end

  assign Money      = money;
  assign Busy       = (state == DISPENSE);
  assign EjectValid = Busy;
  assign EjectType  = Busy ? pick : NICKEL;
endmodule

// File: tb/tb_credit_bank.sv
// Directed vector bench for credit_bank; AUTO_REFUND_EN adds the timeout sequence.
module tb_credit_bank;
  logic       Clk = 1'b0, Reset = 1'b0;
  logic [2:0] Coin = '0;
  logic [6:0] Debit = '0;
  logic       DebitValid = 1'b0, Refund = 1'b0, EjectReady = 1'b0;
  logic [6:0] Money;
  logic       EjectValid, CoinReject, DebitErr, Busy;
  logic [1:0] EjectType;

  int checks = 0, errors = 0;

  credit_bank #(.MAX_CREDIT(127), .IDLE_TIMEOUT(8)) dut (
    .Clk(Clk), .Reset(Reset), .Coin(Coin), .Debit(Debit), .DebitValid(DebitValid),
    .Refund(Refund), .EjectReady(EjectReady), .Money(Money), .EjectValid(EjectValid),
    .EjectType(EjectType), .CoinReject(CoinReject), .DebitErr(DebitErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] coin; logic [6:0] debit; logic dv, rf, rdy;
    logic [6:0] money; logic cr, de, busy, ev; logic [1:0] typ;
  } vec_t;

  vec_t vq[$];

  localparam logic [2:0] N = 3'b001, D = 3'b010, Q = 3'b100, X = 3'b000;

  function automatic vec_t v(input logic [2:0] c, input int deb, input logic dv, rf, rdy,
                             input int m, input logic cr, de, busy, ev, input int t);
    vec_t r;
    r.coin = c; r.debit = 7'(deb); r.dv = dv; r.rf = rf; r.rdy = rdy;
    r.money = 7'(m); r.cr = cr; r.de = de; r.busy = busy; r.ev = ev; r.typ = 2'(t);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_);
    checks++;
    if (act !== exp_) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic [2:0] c, input int deb, input logic dv, rf, rdy);
    Coin = c; Debit = 7'(deb); DebitValid = dv; Refund = rf; EjectReady = rdy;
  endtask

  task automatic chk_flags(input string nm, input logic [6:0] m, input logic cr, de, busy, ev,
                           input logic [1:0] t);
    chk({nm, ".money"}, 16'(Money), 16'(m));
    chk({nm, ".flags"}, 16'({CoinReject, DebitErr, Busy, EjectValid, EjectType}),
        16'({cr, de, busy, ev, t}));
  endtask

  initial begin
    // coin, debit, dv, rf, rdy | money, cr, de, busy, ev, type
    vq.push_back(v(X,  0,0,0,0,   0,0,0,0,0,0));
    vq.push_back(v(Q,  0,0,0,0,  25,0,0,0,0,0));
    vq.push_back(v(D,  0,0,0,0,  35,0,0,0,0,0));
    vq.push_back(v(N,  0,0,0,0,  40,0,0,0,0,0));
    vq.push_back(v(Q, 30,1,0,0,  35,0,0,0,0,0));  // net debit + coin
    vq.push_back(v(X, 50,1,0,0,  35,0,1,0,0,0));  // overdraw
    vq.push_back(v(3'b011,0,0,0,0,35,1,0,0,0,0)); // two coins at once
    vq.push_back(v(Q,  0,0,0,0,  60,0,0,0,0,0));
    vq.push_back(v(Q,  0,0,0,0,  85,0,0,0,0,0));
    vq.push_back(v(Q,  0,0,0,0, 110,0,0,0,0,0));
    vq.push_back(v(D,  0,0,0,0, 120,0,0,0,0,0));
    vq.push_back(v(D,  0,0,0,0, 120,1,0,0,0,0));  // 130 > 127
    vq.push_back(v(N,  0,0,0,0, 125,0,0,0,0,0));
    vq.push_back(v(N,  0,0,0,0, 125,1,0,0,0,0));
    vq.push_back(v(X, 60,1,0,0,  65,0,0,0,0,0));
    vq.push_back(v(X,  0,0,1,1,  65,0,0,1,1,2));  // refund 65: Q,Q,D,N
    vq.push_back(v(X,  0,0,0,1,  40,0,0,1,1,2));
    vq.push_back(v(X,  0,0,0,1,  15,0,0,1,1,1));
    vq.push_back(v(X,  0,0,0,1,   5,0,0,1,1,0));
    vq.push_back(v(X,  0,0,0,1,   0,0,0,0,0,0));
    vq.push_back(v(X,  0,0,1,0,   0,0,0,0,0,0));  // refund at zero ignored
    vq.push_back(v(N,  0,0,0,0,   5,0,0,0,0,0));
    vq.push_back(v(X,  2,1,0,0,   3,0,0,0,0,0));
    vq.push_back(v(X,  0,0,1,0,   0,0,0,0,0,0));  // sub-nickel refund clears
    vq.push_back(v(D,  0,0,0,0,  10,0,0,0,0,0));
    vq.push_back(v(Q,  0,0,0,0,  35,0,0,0,0,0));
    vq.push_back(v(N,  0,0,0,0,  40,0,0,0,0,0));
    vq.push_back(v(X,  0,0,1,0,  40,0,0,1,1,2));  // stalled ejector
    vq.push_back(v(X,  0,0,0,0,  40,0,0,1,1,2));
    vq.push_back(v(Q,  0,0,0,0,  40,1,0,1,1,2));
    vq.push_back(v(X,  5,1,0,0,  40,0,1,1,1,2));
    vq.push_back(v(X,  0,0,1,0,  40,0,0,1,1,2));
    vq.push_back(v(X,  0,0,0,1,  15,0,0,1,1,1));
    vq.push_back(v(X,  0,0,0,1,   5,0,0,1,1,0));
    vq.push_back(v(X,  0,0,0,1,   0,0,0,0,0,0));
    vq.push_back(v(N,  0,0,0,0,   5,0,0,0,0,0));
    vq.push_back(v(N,  0,0,0,0,  10,0,0,0,0,0));
    vq.push_back(v(X,  3,1,0,0,   7,0,0,0,0,0));
    vq.push_back(v(X,  0,0,1,0,   7,0,0,1,1,0));
    vq.push_back(v(X,  0,0,0,1,   0,0,0,0,0,0));  // residue 2 dropped
    vq.push_back(v(Q,  0,0,1,0,  25,0,0,1,1,2));  // coin + refund same cycle
    vq.push_back(v(X,  0,0,0,1,   0,0,0,0,0,0));

    repeat (2) @(negedge Clk);
    chk_flags("reset", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    Reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].coin, int'(vq[i].debit), vq[i].dv, vq[i].rf, vq[i].rdy);
      step();
      chk_flags($sformatf("vec%0d", i), vq[i].money, vq[i].cr, vq[i].de, vq[i].busy,
                vq[i].ev, vq[i].typ);
    end

    // asynchronous reset in the middle of a dispense
    drive(Q, 0, 0, 0, 0); step();
    drive(Q, 0, 0, 0, 0); step();
    drive(X, 0, 0, 1, 0); step();
    drive(X, 0, 0, 0, 0);
    chk_flags("pre_abort", 7'd50, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
    #2 Reset = 1'b0;
    #1 chk_flags("async_abort", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge Clk);
    Reset = 1'b1; EjectReady = 1'b1;
    repeat (3) step();
    chk_flags("after_abort", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef AUTO_REFUND_EN
    begin
      int idle_cycles;
      drive(D, 0, 0, 0, 0); step();
      drive(X, 0, 0, 0, 0);
      chk("auto.money", 16'(Money), 16'd10);
      idle_cycles = 0;
      while (!Busy && idle_cycles < 40) begin
        step();
        idle_cycles++;
      end
      chk("auto.idle_cycles", 16'(idle_cycles), 16'd8);
      EjectReady = 1'b0;
      chk_flags("auto.offer", 7'd10, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      #2 Reset = 1'b0;
      #1 chk_flags("auto.abort", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge Clk);
      Reset = 1'b1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/credit_bank.md
Name: credit_bank

Overview:
Money-side counterpart of the vending purchase logic. It accepts inserted coins into a credit register and presents that credit as Money to the purchase block. It takes debits back from the purchase block when items vend. On a refund request it pays out the remaining credit as change, one coin at a time, through a valid/ready handshake to the coin ejector.

Parameters:
MAX_CREDIT, 127, highest credit value held; it must fit in 7 bits.
IDLE_TIMEOUT, 1000, number of idle cycles before an automatic refund; used only when AUTO_REFUND_EN is defined.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Coin  in  3  one-hot, one-cycle coin pulse: bit0 = 5 (nickel), bit1 = 10 (dime), bit2 = 25 (quarter).
Debit  in  7  cost of the vended item.
DebitValid  in  1  one-cycle pulse qualifying Debit.
Refund  in  1  one-cycle refund request pulse.
EjectReady  in  1  ejector accepts the offered coin.
Money  out  7  current credit.
EjectValid  out  1  a coin is offered to the ejector.
EjectType  out  2  offered coin: 0 = nickel, 1 = dime, 2 = quarter.
CoinReject  out  1  one-cycle pulse: the inserted coin was not credited.
DebitErr  out  1  one-cycle pulse: the debit was refused.
Busy  out  1  high while dispensing change.

Behaviour:
- Reset (asynchronous, Reset=0): Money=0, EjectValid=0, EjectType=0, CoinReject=0, DebitErr=0, Busy=0, state IDLE, timeout counter 0.
- A Reset assertion mid-dispense aborts immediately. The remaining credit is lost and no further coins are offered.
- States:
  - IDLE: apply coins and debits.
  - DISPENSE: offer coins to the ejector.
- IDLE, per cycle; all results are registered and visible one cycle later:
  - Debit is checked first. If DebitValid and Debit <= Money, then Money -= Debit. Otherwise DebitErr pulses and Money is unchanged.
  - Coin is checked against the post-debit credit. If credit + value <= MAX_CREDIT, add the value. Otherwise CoinReject pulses.
  - A Coin input with more than one bit set is invalid: the whole coin is rejected with a CoinReject pulse.
  - A debit and a coin in the same cycle are both applied as net arithmetic. There is no priority loss between them.
  - Refund with post-update credit >= 5 goes to DISPENSE and Busy=1 on the next cycle.
  - Refund with credit 0 is ignored.
  - Refund with credit 1-4 clears Money to 0 and stays in IDLE.
- DISPENSE:
  - EjectValid=1. EjectType is the largest denomination <= Money (greedy 25/10/5).
  - EjectType and EjectValid are held stable until EjectValid && EjectReady.
  - On that handshake Money -= value, effective the next cycle; the next coin is offered in the same cycle the new Money appears. Peak rate is one coin per cycle.
  - When Money < 5: the residue (1-4) is cleared, EjectValid=0, Busy=0, return to IDLE.
  - While in DISPENSE, any coin pulse gives CoinReject, DebitErr is raised for any DebitValid, and Refund is ignored.
- Arithmetic is 7-bit unsigned. Comparisons are done 8 bits wide so the sum cannot wrap past 127.

Optional Feature:
- Macro AUTO_REFUND_EN.
- Defined:
  - In IDLE with Money > 0, a counter increments each cycle that has no Coin, DebitValid or Refund. Any of those events clears it.
  - When the counter reaches IDLE_TIMEOUT-1, an internal Refund fires with identical behaviour to an external Refund.
  - The counter is cleared on entering DISPENSE.
- Undefined: no counter logic exists and credit is held indefinitely.

Decomposition:
- Package vend_pkg:
  - credit_t (logic [6:0]).
  - coin_e enum {NICKEL=0, DIME=1, QUARTER=2}.
  - Constants NICKEL_VAL=5, DIME_VAL=10, QUARTER_VAL=25.
  - Function coin_value(coin_e).
- Sub-module change_picker: combinational. Input credit; outputs coin_e and a valid flag (credit >= 5). It is instantiated once, inside the DISPENSE datapath.

Test Plan:
- Insert quarter, dime, nickel on three separate cycles -> Money = 25, 35, 40. No CoinReject.
- Money=120, insert dime -> CoinReject pulse, Money stays 120. Then insert nickel -> Money=125.
- Money=40, DebitValid with Debit=30 and a quarter pulse in the same cycle -> Money=35. Then Debit=50 -> DebitErr, Money stays 35.
- Money=65, Refund, EjectReady tied 1 -> EjectType sequence QUARTER, QUARTER, DIME, NICKEL on consecutive cycles. Money ends 0, Busy falls, state IDLE.
- Money=40, Refund, EjectReady low for 5 cycles then high -> EjectType=QUARTER held stable with EjectValid=1 throughout. A coin inserted during the stall -> CoinReject.
- With AUTO_REFUND_EN and IDLE_TIMEOUT=8: Money=10, no activity -> dispense starts after 8 idle cycles, DIME offered. Reset asserted mid-dispense -> all outputs 0 asynchronously.
